// File: rtl/linebuf_pp.sv
// Ping-pong sprite line buffer with read-and-clear and post-reset clear sweep.
// Define LINEBUF_PRIO_EN for first-writer-wins (2-stage read-modify-write).
module linebuf_pp #(
    parameter int AW     = 10,
    parameter int DW     = 4,
    parameter int TRANSP = 0
) (
    input  logic          cl,
    input  logic          rst,
    input  logic          swap,
    input  logic          wen,
    input  logic [AW-1:0] wad,
    input  logic [DW-1:0] wdt,
    input  logic          ren,
    input  logic [AW-1:0] rad,
    output logic [DW-1:0] rdt,
    output logic          rvld,
    output logic          busy,
    output logic          bank
);

    localparam logic [DW-1:0] TP = DW'(TRANSP);

    typedef enum logic {
        CLEAR,
        RUN
    } st_t;

    st_t           st, st_n;
    logic [AW-1:0] cnt, cnt_n;

    // both banks in one array; top index bit is the bank
    logic [DW-1:0] mem [2**(AW+1)];

    logic          wacc, racc, swp;
    logic          cw, cwb;
    logic [AW-1:0] cwa;
    logic [DW-1:0] cwd;
    logic          hit;

    always_ff @(posedge cl) begin
        if (rst) begin
            st  <= CLEAR;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        if (st == CLEAR) begin
            cnt_n = cnt + 1'b1;
            if (cnt == '1)
                st_n = RUN;
        end
    end

    assign busy = (st == CLEAR);
    assign wacc = wen && !busy && (wdt != TP);
    assign racc = ren && !busy;
    assign swp  = swap && !busy;

`ifdef LINEBUF_PRIO_EN
    logic          s2v, s2b, occ;
    logic [AW-1:0] s2a;
    logic [DW-1:0] s2d;

    // a pending stage-2 write to the same cell counts as already occupied
    always_comb begin
        occ = (mem[{~bank, wad}] != TP)
            || (s2v && (s2b == ~bank) && (s2a == wad));
    end

    always_ff @(posedge cl) begin
        if (rst) begin
            s2v <= 1'b0;
        end else begin
            s2v <= wacc && !occ;
        end
        s2b <= ~bank;
        s2a <= wad;
        s2d <= wdt;
    end

    assign cw  = s2v;
    assign cwb = s2b;
    assign cwa = s2a;
    assign cwd = s2d;
`else
    assign cw  = wacc;
    assign cwb = ~bank;
    assign cwa = wad;
    assign cwd = wdt;
`endif

    assign hit = cw && (cwb == bank) && (cwa == rad);

    // clear after commit so read-and-clear wins on the same cell
    always_ff @(posedge cl) begin
        if (busy) begin
            mem[{1'b0, cnt}] <= TP;
            mem[{1'b1, cnt}] <= TP;
        end else begin
            if (cw)
                mem[{cwb, cwa}] <= cwd;
            if (racc)
                mem[{bank, rad}] <= TP;
        end
    end

    always_ff @(posedge cl) begin
        if (rst) begin
            bank <= 1'b0;
            rdt  <= TP;
            rvld <= 1'b0;
        end else begin
            rvld <= racc;
            if (racc)
                rdt <= hit ? cwd : mem[{bank, rad}];
            if (swp)
                bank <= ~bank;
        end
    end

endmodule

// File: tb/tb_linebuf_pp.sv
// Scoreboard bench for linebuf_pp against a per-line array model.
module tb_linebuf_pp;

    logic       cl = 1'b0;
    logic       rst, swap, wen, ren;
    logic [9:0] wad, rad;
    logic [3:0] wdt;
    logic [3:0] rdt;
    logic       rvld, busy, bank;

    linebuf_pp #(.AW(10), .DW(4), .TRANSP(0)) dut (
        .cl(cl), .rst(rst), .swap(swap), .wen(wen), .wad(wad),
        .wdt(wdt), .ren(ren), .rad(rad), .rdt(rdt), .rvld(rvld),
        .busy(busy), .bank(bank)
    );

    always #5 cl = ~cl;

    typedef struct {
        logic       v;
        logic [3:0] d;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    logic [3:0] mb[2][1024];
    int         mbusy = 0;
    bit         mrb = 1'b0;
    logic [3:0] mlast = 4'd0;
    bit         started = 1'b0;
    string      phase = "init";

    always @(posedge cl) begin
        #1;
        if (q.size() == 0) begin
            if (rvld === 1'b1) begin
                total++;
                bad++;
                $display("FAIL %s rvld_unexpected got=1 want=0", phase);
            end
        end else begin
            e = q.pop_front();
            total++;
            if (rvld !== e.v) begin
                bad++;
                $display("FAIL %s rvld got=%b want=%b", phase, rvld, e.v);
            end
            total++;
            if (rdt !== e.d) begin
                bad++;
                $display("FAIL %s rdt got=%0d want=%0d", phase, rdt, e.d);
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit we,
                        input int wa, input int wd,
                        input bit re, input int ra);
        logic [9:0] a_w, a_r;
        logic [3:0] d_w;
        exp_t       x;
        a_w = wa[9:0];
        a_r = ra[9:0];
        d_w = wd[3:0];
        @(negedge cl);
        if (started) begin
            total++;
            if (busy !== (mbusy != 0)) begin
                bad++;
                $display("FAIL %s busy got=%b want=%b", phase, busy, mbusy != 0);
            end
            total++;
            if (bank !== mrb) begin
                bad++;
                $display("FAIL %s bank got=%b want=%b", phase, bank, mrb);
            end
        end
        rst  = r;
        swap = s;
        wen  = we;
        wad  = a_w;
        wdt  = d_w;
        ren  = re;
        rad  = a_r;
        x.v  = 1'b0;
        if (r) begin
            mbusy = 1024;
            mrb   = 1'b0;
            mlast = 4'd0;
            foreach (mb[b, i]) mb[b][i] = 4'd0;
        end else if (mbusy != 0) begin
            mbusy--;
        end else begin
            if (re) begin
                mlast       = mb[mrb][a_r];
                mb[mrb][a_r] = 4'd0;
                x.v         = 1'b1;
            end
            if (we && d_w != 4'd0) begin
`ifdef LINEBUF_PRIO_EN
                if (mb[!mrb][a_w] == 4'd0)
                    mb[!mrb][a_w] = d_w;
`else
                mb[!mrb][a_w] = d_w;
`endif
            end
            if (s)
                mrb = !mrb;
        end
        x.d = mlast;
        q.push_back(x);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd(input int amax, input int sdiv);
        step(0, ($urandom_range(0, sdiv - 1) == 0),
             $urandom_range(0, 1), $urandom_range(0, amax),
             $urandom_range(0, 15), $urandom_range(0, 1),
             $urandom_range(0, amax));
    endtask

    initial begin
        rst = 1'b1; swap = 0; wen = 0; ren = 0;
        wad = '0; rad = '0; wdt = '0;

        phase = "reset";
        step(1, 0, 0, 0, 0, 0, 0);
        started = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);

        phase = "sweep";
        for (int i = 0; i < 1024; i++)
            step(0, 1, 1, $urandom_range(0, 1023), $urandom_range(1, 15),
                 1, $urandom_range(0, 1023));

        phase = "blank";
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 1024; a++)
                step(0, 0, 0, 0, 0, 1, a);
            step(0, 1, 0, 0, 0, 0, 0);
        end

        phase = "wrswap";
        step(0, 0, 1, 5, 9, 0, 0);
        step(0, 0, 1, 6, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0, 1, 6);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5);
        idle();

        phase = "swapwr";
        step(0, 1, 1, 3, 7, 0, 0);
        step(0, 0, 0, 0, 0, 1, 3);
        idle();

        phase = "collide";
        step(0, 0, 1, 8, 2, 0, 0);
        step(0, 0, 1, 8, 4, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 8);
        idle();

        phase = "midrst";
        for (int i = 0; i < 200; i++)
            rnd(15, 8);
        step(1, 0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 500; i++)
            rnd(1023, 4);
        step(1, 1, 1, 2, 2, 1, 2);
        for (int i = 0; i < 1024; i++)
            rnd(1023, 4);
        for (int i = 0; i < 300; i++)
            rnd(15, 8);

        phase = "stream";
        for (int a = 0; a < 1024; a++)
            step(0, 0, 1, a, $urandom_range(1, 15), 1, a);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int a = 0; a < 1024; a++)
            step(0, 0, 1, $urandom_range(0, 1023), $urandom_range(0, 15), 1, a);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1499) == 0)
                step(1, 0, 0, 0, 0, 0, 0);
            else
                rnd(15, 16);
        end
        idle();

        @(posedge cl);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
